// File: rtl/ravenoc_pkg.sv
// Shared NoC definitions: flit types, field widths and the head-flit layout.
// Every block that encodes or decodes a head flit uses these.
package ravenoc_pkg;

  localparam int NOC_MAX_SZ_PKT = 256;
  localparam int X_W            = 2;
  localparam int Y_W            = 2;
  localparam int FLIT_DATA_W    = 32;
  localparam int PKT_LEN_W      = $clog2(NOC_MAX_SZ_PKT + 1);
  localparam int HEAD_RSVD_W    = FLIT_DATA_W - (2 * X_W) - (2 * Y_W) - PKT_LEN_W;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  // Fields are listed MSB first.
  typedef struct packed {
    logic [X_W-1:0]         x_dest;
    logic [Y_W-1:0]         y_dest;
    logic [X_W-1:0]         x_src;
    logic [Y_W-1:0]         y_src;
    logic [PKT_LEN_W-1:0]   pkt_size;
    logic [HEAD_RSVD_W-1:0] rsvd;
  } s_flit_head_data_t;

endpackage

// File: rtl/ni_packetizer.sv
// Network-interface packetizer: turns a packet command plus payload beats
// into HEAD/BODY/TAIL flits for the router local port.
module ni_packetizer
  import ravenoc_pkg::*;
#(
  parameter int ROUTER_X_ID = 0,
  parameter int ROUTER_Y_ID = 0,
  parameter int MAX_SZ_PKT  = 256
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   pkt_valid_i,
  output logic                   pkt_ready_o,
  input  logic [X_W-1:0]         pkt_dst_x_i,
  input  logic [Y_W-1:0]         pkt_dst_y_i,
  input  logic [PKT_LEN_W-1:0]   pkt_len_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  input  logic [FLIT_DATA_W-1:0] data_i,
  output logic                   flit_valid_o,
  input  logic                   flit_ready_i,
  output flit_type_t             flit_type_o,
  output logic [FLIT_DATA_W-1:0] flit_data_o,
  output logic                   len_err_o,
  output logic [15:0]            pkt_cnt_o
);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  localparam logic [PKT_LEN_W-1:0] MAX_LEN = PKT_LEN_W'(MAX_SZ_PKT);
  localparam logic [PKT_LEN_W-1:0] ONE_LEN = PKT_LEN_W'(1);

  state_t               state;
  logic [PKT_LEN_W-1:0] beat_cnt;
  logic                 can_load;
  logic                 flit_done;
  s_flit_head_data_t    head;

  assign can_load  = !flit_valid_o || flit_ready_i;
  assign flit_done = flit_valid_o && flit_ready_i;

  // Readies are gated by reset so nothing looks accepted while arst is held low.
  assign pkt_ready_o  = arst && (state == IDLE) && can_load;
  assign data_ready_o = arst && (state == PAYLOAD) && can_load;

  always_comb begin
    head          = '0;
    head.x_dest   = pkt_dst_x_i;
    head.y_dest   = pkt_dst_y_i;
    head.x_src    = X_W'(ROUTER_X_ID);
    head.y_src    = Y_W'(ROUTER_Y_ID);
    head.pkt_size = pkt_len_i;
  end

  // A flit handshake clears valid first; a flit loading in the same edge
  // overrides that, which gives one flit per cycle under continuous ready.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      flit_valid_o <= 1'b0;
      flit_type_o  <= HEAD;
      flit_data_o  <= '0;
      len_err_o    <= 1'b0;
      pkt_cnt_o    <= '0;
    end else begin
      len_err_o <= 1'b0;
      if (flit_done) begin
        flit_valid_o <= 1'b0;
        if (flit_type_o == TAIL || flit_type_o == HEAD_TAIL) begin
          pkt_cnt_o <= pkt_cnt_o + 16'd1;
        end
      end
      case (state)
        IDLE: begin
          if (pkt_valid_i && pkt_ready_o) begin
            if (pkt_len_i > MAX_LEN) begin
              len_err_o <= 1'b1;
            end else begin
              flit_valid_o <= 1'b1;
              flit_data_o  <= head;
              if (pkt_len_i == '0) begin
                flit_type_o <= HEAD_TAIL;
              end else begin
                flit_type_o <= HEAD;
                beat_cnt    <= pkt_len_i;
                state       <= PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (data_valid_i && data_ready_o) begin
            flit_valid_o <= 1'b1;
            flit_data_o  <= data_i;
            beat_cnt     <= beat_cnt - ONE_LEN;
            if (beat_cnt == ONE_LEN) begin
              flit_type_o <= TAIL;
              state       <= IDLE;
            end else begin
              flit_type_o <= BODY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer; expected flits and head words are
// worked out by hand from the head layout (dst_x, dst_y, src_x, src_y, len, zeros).
module tb_ni_packetizer;
  import ravenoc_pkg::*;

  logic                   clk;
  logic                   arst;
  logic                   pkt_valid_i;
  logic                   pkt_ready_o;
  logic [X_W-1:0]         pkt_dst_x_i;
  logic [Y_W-1:0]         pkt_dst_y_i;
  logic [PKT_LEN_W-1:0]   pkt_len_i;
  logic                   data_valid_i;
  logic                   data_ready_o;
  logic [FLIT_DATA_W-1:0] data_i;
  logic                   flit_valid_o;
  logic                   flit_ready_i;
  flit_type_t             flit_type_o;
  logic [FLIT_DATA_W-1:0] flit_data_o;
  logic                   len_err_o;
  logic [15:0]            pkt_cnt_o;

  int numChecks = 0;
  int numFails  = 0;

  ni_packetizer #(
    .ROUTER_X_ID(0),
    .ROUTER_Y_ID(0),
    .MAX_SZ_PKT (256)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .pkt_valid_i (pkt_valid_i),
    .pkt_ready_o (pkt_ready_o),
    .pkt_dst_x_i (pkt_dst_x_i),
    .pkt_dst_y_i (pkt_dst_y_i),
    .pkt_len_i   (pkt_len_i),
    .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .data_i      (data_i),
    .flit_valid_o(flit_valid_o),
    .flit_ready_i(flit_ready_i),
    .flit_type_o (flit_type_o),
    .flit_data_o (flit_data_o),
    .len_err_o   (len_err_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    assert (observed === expected)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and let registered outputs settle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlit(input string tag, input logic [1:0] expType,
                           input logic [31:0] expData);
    checkOutput({tag, "_valid"}, 32'(flit_valid_o), 32'd1);
    checkOutput({tag, "_type"}, 32'(flit_type_o), 32'(expType));
    checkOutput({tag, "_data"}, flit_data_o, expData);
  endtask

  task automatic sendCmd(input logic [1:0] dx, input logic [1:0] dy, input int len);
    pkt_valid_i = 1'b1;
    pkt_dst_x_i = dx;
    pkt_dst_y_i = dy;
    pkt_len_i   = PKT_LEN_W'(len);
  endtask

  initial begin
    arst = 1'b0;
    pkt_valid_i = 1'b0; pkt_dst_x_i = '0; pkt_dst_y_i = '0; pkt_len_i = '0;
    data_valid_i = 1'b0; data_i = '0; flit_ready_i = 1'b1;
    #1;
    checkOutput("rst_flit_valid", 32'(flit_valid_o), 32'd0);
    checkOutput("rst_flit_type", 32'(flit_type_o), 32'd0);
    checkOutput("rst_flit_data", flit_data_o, 32'd0);
    checkOutput("rst_len_err", 32'(len_err_o), 32'd0);
    checkOutput("rst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
    checkOutput("rst_pkt_ready", 32'(pkt_ready_o), 32'd0);
    checkOutput("rst_data_ready", 32'(data_ready_o), 32'd0);
    applyStimulus();
    @(negedge clk);
    arst = 1'b1;
    #1;
    checkOutput("post_rst_pkt_ready", 32'(pkt_ready_o), 32'd1);

    // Basic packet: dst (1,2), len 3.
    sendCmd(2'd1, 2'd2, 3);
    applyStimulus();
    checkFlit("basic_head", 2'b00, 32'h6001_8000);
    pkt_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 32'hA;
    #1;
    checkOutput("basic_data_ready", 32'(data_ready_o), 32'd1);
    checkOutput("basic_pkt_ready", 32'(pkt_ready_o), 32'd0);
    applyStimulus();
    checkFlit("basic_body0", 2'b01, 32'hA);
    data_i = 32'hB;
    applyStimulus();
    checkFlit("basic_body1", 2'b01, 32'hB);
    data_i = 32'hC;
    applyStimulus();
    checkFlit("basic_tail", 2'b10, 32'hC);
    data_valid_i = 1'b0;
    applyStimulus();
    checkOutput("basic_pkt_cnt", 32'(pkt_cnt_o), 32'd1);
    checkOutput("basic_idle_valid", 32'(flit_valid_o), 32'd0);

    // Zero-length packet, with a stray beat offered in IDLE.
    sendCmd(2'd3, 2'd1, 0);
    data_valid_i = 1'b1; data_i = 32'hDEAD;
    #1;
    checkOutput("zero_data_ready_pre", 32'(data_ready_o), 32'd0);
    applyStimulus();
    checkFlit("zero_ht", 2'b11, 32'hD000_0000);
    pkt_valid_i = 1'b0;
    #1;
    checkOutput("zero_data_ready_post", 32'(data_ready_o), 32'd0);
    applyStimulus();
    data_valid_i = 1'b0;
    checkOutput("zero_pkt_cnt", 32'(pkt_cnt_o), 32'd2);
    checkOutput("zero_idle_valid", 32'(flit_valid_o), 32'd0);

    // Over-length packet: len 257.
    sendCmd(2'd1, 2'd1, 257);
    applyStimulus();
    checkOutput("over_len_err", 32'(len_err_o), 32'd1);
    checkOutput("over_no_flit", 32'(flit_valid_o), 32'd0);
    pkt_valid_i = 1'b0;
    applyStimulus();
    checkOutput("over_len_err_clr", 32'(len_err_o), 32'd0);
    checkOutput("over_pkt_cnt", 32'(pkt_cnt_o), 32'd2);
    checkOutput("over_no_flit2", 32'(flit_valid_o), 32'd0);

    // Backpressure: len 2, router stalls 5 cycles after the first body flit.
    sendCmd(2'd2, 2'd3, 2);
    applyStimulus();
    checkFlit("bp_head", 2'b00, 32'hB001_0000);
    pkt_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 32'h11;
    applyStimulus();
    checkFlit("bp_body", 2'b01, 32'h11);
    flit_ready_i = 1'b0; data_i = 32'h22;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_data_ready_stall", 32'(data_ready_o), 32'd0);
      applyStimulus();
      checkFlit("bp_hold", 2'b01, 32'h11);
    end
    flit_ready_i = 1'b1;
    #1;
    checkOutput("bp_data_ready_resume", 32'(data_ready_o), 32'd1);
    applyStimulus();
    checkFlit("bp_tail", 2'b10, 32'h22);
    data_valid_i = 1'b0;
    applyStimulus();
    checkOutput("bp_pkt_cnt", 32'(pkt_cnt_o), 32'd3);

    // Back-to-back len 1 packets with valids held high.
    sendCmd(2'd1, 2'd1, 1);
    applyStimulus();
    checkFlit("b2b_head0", 2'b00, 32'h5000_8000);
    data_valid_i = 1'b1; data_i = 32'h55;
    applyStimulus();
    checkFlit("b2b_tail0", 2'b10, 32'h55);
    data_i = 32'h66;
    #1;
    checkOutput("b2b_pkt_ready_on_tail", 32'(pkt_ready_o), 32'd1);
    applyStimulus();
    checkFlit("b2b_head1", 2'b00, 32'h5000_8000);
    pkt_valid_i = 1'b0;
    applyStimulus();
    checkFlit("b2b_tail1", 2'b10, 32'h66);
    data_valid_i = 1'b0;
    applyStimulus();
    checkOutput("b2b_pkt_cnt", 32'(pkt_cnt_o), 32'd5);

    // Reset after the 2nd of 4 beats.
    sendCmd(2'd0, 2'd3, 4);
    applyStimulus();
    pkt_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 32'h1;
    applyStimulus();
    data_i = 32'h2;
    applyStimulus();
    checkFlit("mid_body1", 2'b01, 32'h2);
    arst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(flit_valid_o), 32'd0);
    checkOutput("mid_rst_type", 32'(flit_type_o), 32'd0);
    checkOutput("mid_rst_data", flit_data_o, 32'd0);
    checkOutput("mid_rst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
    checkOutput("mid_rst_pkt_ready", 32'(pkt_ready_o), 32'd0);
    checkOutput("mid_rst_data_ready", 32'(data_ready_o), 32'd0);
    @(negedge clk);
    arst = 1'b1;
    data_valid_i = 1'b0;
    sendCmd(2'd1, 2'd2, 1);
    applyStimulus();
    checkFlit("after_rst_head", 2'b00, 32'h6000_8000);
    pkt_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 32'h77;
    applyStimulus();
    checkFlit("after_rst_tail", 2'b10, 32'h77);
    data_valid_i = 1'b0;
    applyStimulus();
    checkOutput("after_rst_pkt_cnt", 32'(pkt_cnt_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/ni_packetizer.md
NI_PACKETIZER -- requirements
Module: ni_packetizer

Interface
REQ-001 Parameters SHALL be: ROUTER_X_ID, default 0, source X coordinate placed in head flits; ROUTER_Y_ID, default 0, source Y coordinate; MAX_SZ_PKT, default 256, maximum payload beats per packet.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  the single clock.
- arst  in  1  asynchronous, active-low reset.
- pkt_valid_i  in  1  packet command valid.
- pkt_ready_o  out  1  packet command accepted.
- pkt_dst_x_i  in  X_W  destination X.
- pkt_dst_y_i  in  Y_W  destination Y.
- pkt_len_i  in  PKT_LEN_W  payload beat count.
- data_valid_i  in  1  payload beat valid.
- data_ready_o  out  1  payload beat accepted.
- data_i  in  FLIT_DATA_W  payload beat.
- flit_valid_o  out  1  flit valid toward the router local port.
- flit_ready_i  in  1  router accepts the flit.
- flit_type_o  out  flit_type_t  HEAD, BODY, TAIL or HEAD_TAIL.
- flit_data_o  out  FLIT_DATA_W  flit payload.
- len_err_o  out  1  one-cycle pulse when a command is rejected.
- pkt_cnt_o  out  16  count of packets fully sent.

Function
REQ-003 The FSM SHALL have the states IDLE and PAYLOAD.
REQ-004 The output flit register SHALL be loadable when flit_valid_o=0 or flit_ready_i=1 ("can_load").
REQ-005 The block SHALL drive pkt_ready_o = (state==IDLE) && can_load; a command handshake occurs when pkt_valid_i && pkt_ready_o.
REQ-006 On a handshake with 1<=pkt_len_i<=MAX_SZ_PKT, the block SHALL load the head flit on the next edge and go to PAYLOAD with the beat counter set to pkt_len_i.
- flit_type_o = HEAD.
- flit_data_o = {dst_x, dst_y, ROUTER_X_ID, ROUTER_Y_ID, pkt_len, zero fill}, MSB first.
REQ-007 On a handshake with pkt_len_i==0, the block SHALL emit a single HEAD_TAIL head flit and remain in IDLE.
REQ-008 On a handshake with pkt_len_i>MAX_SZ_PKT, the block SHALL emit no flit, pulse len_err_o for one cycle and remain in IDLE.
REQ-009 The block SHALL drive data_ready_o = (state==PAYLOAD) && can_load, and 0 in IDLE.
REQ-010 Each accepted beat SHALL load flit_data_o = data_i on the next edge and decrement the counter.
- flit_type_o = BODY while counter>1.
- flit_type_o = TAIL when counter==1; the FSM then returns to IDLE in the same edge.
REQ-011 While flit_valid_o=1 and flit_ready_i=0, flit_valid_o, flit_type_o and flit_data_o SHALL hold stable.
REQ-012 flit_valid_o SHALL be cleared on a flit_ready_i handshake unless a new flit loads in the same cycle.
REQ-013 Back-to-back transfers SHALL sustain one flit per cycle when flit_ready_i stays 1.
REQ-014 Command-to-head latency SHALL be 1 cycle, and beat-to-flit latency SHALL be 1 cycle.
REQ-015 pkt_cnt_o SHALL increment by one when a TAIL or HEAD_TAIL flit completes its handshake, and SHALL wrap from 0xFFFF to 0.
REQ-016 Inputs data_valid_i in IDLE SHALL be ignored (not consumed).
REQ-017 A new command SHALL be accepted in the same cycle the previous TAIL is being drained, provided can_load holds.

Reset
REQ-018 Asserting arst low SHALL asynchronously force the following, regardless of state and discarding any partial packet:
- state = IDLE, counter = 0.
- flit_valid_o = 0, flit_type_o = HEAD, flit_data_o = 0.
- len_err_o = 0, pkt_cnt_o = 0.
- pkt_ready_o = 0 and data_ready_o = 0 while in reset.
REQ-019 After arst deasserts, pkt_ready_o SHALL be 1 on the first cycle.

Structure
REQ-020 ravenoc_pkg SHALL hold the following, so that input_module decodes the same head format:
- flit_type_t.
- X_W, Y_W, FLIT_DATA_W and PKT_LEN_W = $clog2(MAX_SZ_PKT+1).
- s_flit_head_data_t, the head-flit layout.
REQ-021 The block SHALL be a single module with no sub-modules; the output register and the FSM SHALL be local.

Verification
REQ-022 Directed scenarios:
- Basic packet: cmd dst=(1,2), len=3, beats 0xA,0xB,0xC, ready always 1 -> HEAD{1,2,0,0,3}, BODY 0xA, BODY 0xB, TAIL 0xC on consecutive cycles, then pkt_cnt_o=1.
- Zero-length packet: len=0 -> one HEAD_TAIL flit, data_ready_o never asserted.
- Over-length packet: len=MAX_SZ_PKT+1 -> len_err_o pulses once, no flit_valid_o, pkt_cnt_o unchanged.
- Backpressure: flit_ready_i low for 5 cycles mid-packet -> flit held stable, data_ready_o=0, no beat lost or duplicated.
- Back-to-back: two len=1 packets with continuous valids -> HEAD,TAIL,HEAD,TAIL in 4 consecutive cycles.
- Reset mid-packet: arst low after the 2nd of 4 beats -> outputs at reset values immediately; the next packet is clean and starts with HEAD.
